// File: rtl/spi_slave.sv
// spi_slave -- SPI mode-0 (CPOL=0, CPHA=0) responder clocked by the system clock.
//
// The external SCLK/SS_n/MOSI pins are oversampled through synchronizer chains.
// Frames are 8-bit (MSbit first) or 32-bit (byte 0 first, each byte MSbit first).
// A one-deep transmit holding register and a receive register with a valid/ack
// handshake face the local bus.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   word              frame size (0 = 8-bit, 1 = 32-bit), latched at frame start
//   dataTx, txLoad    transmit data and its one-cycle write strobe
//   txRdy             holding register empty
//   dataRx, rxValid   last received frame and its valid flag
//   rxAck             one-cycle strobe clearing rxValid and overrun
//   overrun           sticky: a frame completed while rxValid was still set
//   SCLK, SS_n, MOSI  asynchronous SPI pins
//   MISO, MISO_oe     serial data out (1 when idle) and its tri-state enable
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        word,
  input  logic [31:0] dataTx,
  input  logic        txLoad,
  output logic        txRdy,
  output logic [31:0] dataRx,
  output logic        rxValid,
  input  logic        rxAck,
  output logic        overrun,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_q;
  logic                   ss_q;

  logic        sclk_s, ss_s, mosi_s;
  logic        frame_start, frame_abort, in_frame;
  logic        sclk_rise, sclk_fall;
  logic        last_bit, reload;
  logic [31:0] reload_val;
  logic [31:0] rx_word;
  logic [4:0]  idx, bitcnt_nx, idx_nx;

  logic [31:0] hold;
  logic [31:0] txsh;
  logic [31:0] rxsh;
  logic [4:0]  bitcnt;
  logic        word_q;
  logic        miso_r;

  // MOSI goes through the same depth as SCLK so the sampled bit lines up with
  // the detected rising edge. SS_n resets high so the bus looks idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign frame_start = ~ss_s & ss_q;
  assign frame_abort = ss_s & ~ss_q;
  // SCLK edges count only while the slave has been selected for at least one cycle.
  assign in_frame    = ~ss_s & ~ss_q;
  assign sclk_rise   = in_frame & sclk_s & ~sclk_q;
  assign sclk_fall   = in_frame & ~sclk_s & sclk_q;

  // The inverted low bits give MSbit-first order within each byte while the
  // upper bits step through bytes 0..3 in order.
  assign idx       = {bitcnt[4:3], ~bitcnt[2:0]};
  assign bitcnt_nx = bitcnt + 5'd1;
  assign idx_nx    = {bitcnt_nx[4:3], ~bitcnt_nx[2:0]};
  assign last_bit  = word_q ? (bitcnt == 5'd31) : (bitcnt == 5'd7);

  // An empty holding register sends the all-ones underrun fill.
  assign reload     = frame_start | (sclk_fall & last_bit);
  assign reload_val = txRdy ? 32'hFFFF_FFFF : hold;

  always_comb begin
    rx_word      = rxsh;
    rx_word[idx] = mosi_s;
  end

  // Transmit side. A txLoad in the same cycle as a reload lands in the holding
  // register after the old content has moved to the shifter, so it wins txRdy.
  // Bit 0 of a new frame always has index 7, hence reload_val[7] on MISO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold   <= '1;
      txRdy  <= 1'b1;
      txsh   <= '1;
      bitcnt <= '0;
      word_q <= 1'b0;
      miso_r <= 1'b1;
    end else begin
      if (reload) begin
        txsh  <= reload_val;
        txRdy <= 1'b1;
      end
      if (txLoad) begin
        hold  <= dataTx;
        txRdy <= 1'b0;
      end
      if (frame_start) begin
        word_q <= word;
        bitcnt <= '0;
        miso_r <= reload_val[7];
      end else if (frame_abort) begin
        bitcnt <= '0;
        miso_r <= 1'b1;
      end else if (sclk_fall) begin
        if (last_bit) begin
          bitcnt <= '0;
          miso_r <= reload_val[7];
        end else begin
          bitcnt <= bitcnt_nx;
          miso_r <= txsh[idx_nx];
        end
      end
    end
  end

  // Receive side. An ack coinciding with a commit frees the register in time,
  // so the new frame is taken and overrun stays clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxsh    <= '1;
      dataRx  <= '0;
      rxValid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (rxAck) begin
        rxValid <= 1'b0;
        overrun <= 1'b0;
      end
      if (sclk_rise) begin
        rxsh <= rx_word;
        if (last_bit) begin
          if (!rxValid || rxAck) begin
            dataRx  <= word_q ? rx_word : {24'b0, rx_word[7:0]};
            rxValid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign MISO    = miso_r;
  assign MISO_oe = ~ss_s;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave -- self-checking bench for spi_slave.
//
// A behavioural SPI master drives the pins on falling clk edges; a small
// transaction-level model of the holding register and receive handshake
// predicts MISO words and dataRx/rxValid/overrun.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        word;
  logic [31:0] dataTx;
  logic        txLoad;
  logic        txRdy;
  logic [31:0] dataRx;
  logic        rxValid;
  logic        rxAck;
  logic        overrun;
  logic        SCLK;
  logic        SS_n;
  logic        MOSI;
  logic        MISO;
  logic        MISO_oe;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] mHold;
  bit          mFull;
  logic [31:0] mData;
  bit          mValid;
  bit          mOverrun;
  logic [31:0] curTx;
  logic [31:0] dummy;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .word(word), .dataTx(dataTx), .txLoad(txLoad),
    .txRdy(txRdy), .dataRx(dataRx), .rxValid(rxValid), .rxAck(rxAck),
    .overrun(overrun), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Taking the next transmit word empties the holding register or yields fill.
  function automatic logic [31:0] consumeTx();
    if (mFull) begin
      mFull = 1'b0;
      return mHold;
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic void modelCommit(input logic [31:0] v, input bit isWord, input bit ack);
    logic [31:0] val;
    val = isWord ? v : {24'b0, v[7:0]};
    if (mValid && !ack) begin
      mOverrun = 1'b1;
    end else begin
      mData  = val;
      mValid = 1'b1;
      if (ack) mOverrun = 1'b0;
    end
  endfunction

  function automatic void modelReset();
    mFull    = 1'b0;
    mValid   = 1'b0;
    mData    = '0;
    mOverrun = 1'b0;
  endfunction

  task automatic checkRx(input string tag);
    checkOutput({tag, ".rxValid"}, {31'b0, rxValid}, {31'b0, mValid});
    checkOutput({tag, ".dataRx"}, dataRx, mData);
    checkOutput({tag, ".overrun"}, {31'b0, overrun}, {31'b0, mOverrun});
  endtask

  task automatic pulseAck();
    @(negedge clk) rxAck = 1'b1;
    @(negedge clk) rxAck = 1'b0;
    mValid   = 1'b0;
    mOverrun = 1'b0;
  endtask

  task automatic loadTx(input logic [31:0] v);
    @(negedge clk);
    dataTx = v;
    txLoad = 1'b1;
    @(negedge clk) txLoad = 1'b0;
    mHold = v;
    mFull = 1'b1;
    checkOutput("txRdy.load", {31'b0, txRdy}, 32'd0);
  endtask

  task automatic ssDown(input bit isWord);
    @(negedge clk);
    word = isWord;
    SS_n = 1'b0;
    repeat (4) @(negedge clk);
    curTx = consumeTx();
    checkOutput("txRdy.start", {31'b0, txRdy}, 32'd1);
    checkOutput("oe.active", {31'b0, MISO_oe}, 32'd1);
  endtask

  task automatic ssUp();
    repeat (6) @(negedge clk);
    SS_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("miso.idle", {31'b0, MISO}, 32'd1);
    checkOutput("oe.idle", {31'b0, MISO_oe}, 32'd0);
  endtask

  // Bytes go out in order 0..3, each MSbit first; MISO is sampled just before
  // each rising SCLK, 6 clk into the low phase. An optional txLoad pulse sits
  // in the low phase of bit loadBit, and an optional rxAck lands on the commit
  // cycle of the last bit (third clk edge after SCLK rises).
  task automatic runBits(input int nbits, input logic [31:0] mosiVal, input int loadBit,
                         input logic [31:0] loadVal, input bit ackLast,
                         output logic [31:0] misoVal);
    misoVal = '0;
    for (int k = 0; k < nbits; k++) begin
      int p;
      p = (k / 8) * 8 + (7 - (k % 8));
      MOSI = mosiVal[p];
      if (k == loadBit) begin
        @(negedge clk);
        dataTx = loadVal;
        txLoad = 1'b1;
        @(negedge clk) txLoad = 1'b0;
        mHold = loadVal;
        mFull = 1'b1;
        repeat (4) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      misoVal[p] = MISO;
      SCLK = 1'b1;
      if (ackLast && k == nbits - 1) begin
        repeat (2) @(negedge clk);
        rxAck = 1'b1;
        @(negedge clk) rxAck = 1'b0;
        repeat (3) @(negedge clk);
      end else begin
        repeat (6) @(negedge clk);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic doFrame(input bit isWord, input logic [31:0] mosiVal, input int loadBit,
                         input logic [31:0] loadVal, input bit ackLast, input string tag);
    logic [31:0] got;
    logic [31:0] expTx;
    expTx = curTx;
    runBits(isWord ? 32 : 8, mosiVal, loadBit, loadVal, ackLast, got);
    if (ackLast) begin
      mValid   = 1'b0;
      mOverrun = 1'b0;
    end
    modelCommit(mosiVal, isWord, ackLast);
    curTx = consumeTx();
    if (isWord)
      checkOutput({tag, ".miso"}, got, expTx);
    else
      checkOutput({tag, ".miso"}, {24'b0, got[7:0]}, {24'b0, expTx[7:0]});
    checkRx(tag);
  endtask

  task automatic applyStimulus(input bit isWord, input logic [31:0] mosiVal, input bit ackLast,
                               input string tag);
    ssDown(isWord);
    doFrame(isWord, mosiVal, -1, 32'h0, ackLast, tag);
    ssUp();
  endtask

  initial begin
    rst    = 1'b1;
    word   = 1'b0;
    dataTx = '0;
    txLoad = 1'b0;
    rxAck  = 1'b0;
    SCLK   = 1'b0;
    SS_n   = 1'b1;
    MOSI   = 1'b0;
    modelReset();
    curTx = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    checkOutput("reset.txRdy", {31'b0, txRdy}, 32'd1);
    checkOutput("reset.MISO", {31'b0, MISO}, 32'd1);
    checkOutput("reset.MISO_oe", {31'b0, MISO_oe}, 32'd0);
    checkRx("reset");

    $display("[TB] byte mode");
    loadTx(32'h0000_00A5);
    applyStimulus(1'b0, 32'h0000_003C, 1'b0, "byte");

    $display("[TB] word mode");
    pulseAck();
    loadTx(32'h1234_5678);
    applyStimulus(1'b1, 32'hCAFE_BABE, 1'b0, "word");

    $display("[TB] underrun and back-to-back");
    pulseAck();
    applyStimulus(1'b0, 32'h0000_0096, 1'b0, "underrun");
    pulseAck();
    ssDown(1'b0);
    doFrame(1'b0, 32'h0000_0021, 3, 32'h0000_0011, 1'b0, "b2b.first");
    doFrame(1'b0, 32'h0000_0043, -1, 32'h0, 1'b0, "b2b.second");
    ssUp();

    $display("[TB] overrun");
    pulseAck();
    applyStimulus(1'b0, 32'h0000_0001, 1'b0, "ovr.first");
    applyStimulus(1'b0, 32'h0000_0002, 1'b0, "ovr.second");
    pulseAck();
    checkRx("ovr.ack");
    applyStimulus(1'b0, 32'h0000_0003, 1'b0, "ovr.third");
    applyStimulus(1'b0, 32'h0000_0004, 1'b1, "ovr.coincident");

    $display("[TB] abort");
    pulseAck();
    loadTx(32'h0000_0077);
    ssDown(1'b0);
    runBits(4, 32'h0000_00F0, -1, 32'h0, 1'b0, dummy);
    ssUp();
    checkRx("abort");
    loadTx(32'h0000_003E);
    applyStimulus(1'b0, 32'h0000_005A, 1'b0, "after_abort");

    $display("[TB] reset mid-frame");
    pulseAck();
    loadTx(32'h0000_0099);
    ssDown(1'b0);
    runBits(3, 32'h0000_00B7, -1, 32'h0, 1'b0, dummy);
    @(negedge clk) rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst.txRdy", {31'b0, txRdy}, 32'd1);
    checkOutput("rst.MISO", {31'b0, MISO}, 32'd1);
    checkOutput("rst.MISO_oe", {31'b0, MISO_oe}, 32'd0);
    checkRx("rst");
    @(negedge clk) rst = 1'b0;
    ssUp();
    applyStimulus(1'b0, 32'h0000_00C3, 1'b0, "after_rst");

    $display("[TB] randomized frames");
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) != 0) pulseAck();
      if ($urandom_range(0, 1) == 1) loadTx($urandom);
      applyStimulus(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
